// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer: FSM state encoding,
// keypad code width and default codes, plus a timer-width helper.
package alarm_pkg;

    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] ARM_CODE_DEF    = 5'd31;
    localparam logic [CODE_W-1:0] DISARM_CODE_DEF = 5'd4;

    typedef enum logic [2:0] {
        DISARMED,
        EXIT,
        ARMED,
        ENTRY,
        ALARM
    } state_t;

    // Down-counters hold at most (cycles-1), so $clog2 of the largest length suffices.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Keypad/sensor inputs and status/siren outputs of the alarm sequencer.
interface alarm_sequencer_if;
    import alarm_pkg::*;

    logic              motion1;
    logic              motion2;
    logic              reed;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              active;
    logic              pending;
    logic              alarm;
    logic              siren;
    logic              alarm_mem;
    logic              locked;

    modport master (
        output motion1, motion2, reed, code, code_valid,
        input  active, pending, alarm, siren, alarm_mem, locked
    );

    modport slave (
        input  motion1, motion2, reed, code, code_valid,
        output active, pending, alarm, siren, alarm_mem, locked
    );

endinterface

// File: rtl/code_lockout.sv
// Keypad code decoder with consecutive-wrong-code counter and keypad lockout.
// Hit strobes are combinational so the FSM reacts on the same clock edge.
module code_lockout
    import alarm_pkg::*;
#(
    parameter logic [CODE_W-1:0] ARM_CODE       = ARM_CODE_DEF,
    parameter logic [CODE_W-1:0] DISARM_CODE    = DISARM_CODE_DEF,
    parameter int                MAX_FAILS      = 3,
    parameter int                LOCKOUT_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              arm_hit,
    output logic              disarm_hit,
    output logic              wrong,
    output logic              locked
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic          accept;
    logic [FW-1:0] fails;
    logic [LW-1:0] lock_timer;

    assign accept     = code_valid && !locked;
    assign arm_hit    = accept && (code == ARM_CODE);
    // Arm takes precedence should both codes ever be configured identically.
    assign disarm_hit = accept && (code == DISARM_CODE) && (code != ARM_CODE);
    assign wrong      = accept && !arm_hit && !disarm_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fails      <= '0;
            locked     <= 1'b0;
            lock_timer <= '0;
        end else if (locked) begin
            if (lock_timer == '0) begin
                locked <= 1'b0;
                fails  <= '0;
            end else begin
                lock_timer <= lock_timer - LW'(1);
            end
        end else if (arm_hit || disarm_hit) begin
            fails <= '0;
        end else if (wrong) begin
            if (fails >= FAIL_LAST) begin
                fails      <= FAIL_MAX;
                locked     <= 1'b1;
                lock_timer <= LOCK_LOAD;
            end else begin
                fails <= fails + FW'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Home alarm sequencing controller: arm/disarm FSM with exit and entry delays,
// bounded siren, sticky alarm memory and a keypad lockout sub-block.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter logic [CODE_W-1:0] ARM_CODE       = ARM_CODE_DEF,
    parameter logic [CODE_W-1:0] DISARM_CODE    = DISARM_CODE_DEF,
    parameter int                EXIT_CYCLES    = 1000,
    parameter int                ENTRY_CYCLES   = 500,
    parameter int                SIREN_CYCLES   = 3000,
    parameter int                MAX_FAILS      = 3,
    parameter int                LOCKOUT_CYCLES = 2000
) (
    input logic               clk,
    input logic               rst_n,
    alarm_sequencer_if.slave  sys
);

    localparam int TW = timer_width(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES);
    localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYCLES - 1);
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYCLES - 1);
    localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          arm_hit;
    logic          disarm_hit;
    logic          unused_wrong;
    logic          intrude;
    logic          door;

    assign intrude = sys.motion1 || sys.motion2;
    assign door    = sys.reed;

    code_lockout #(
        .ARM_CODE       (ARM_CODE),
        .DISARM_CODE    (DISARM_CODE),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_code_lockout (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (sys.code),
        .code_valid (sys.code_valid),
        .arm_hit    (arm_hit),
        .disarm_hit (disarm_hit),
        .wrong      (unused_wrong),
        .locked     (sys.locked)
    );

    // Outputs are assigned alongside the state they belong to, so they
    // always reflect the state being entered on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= DISARMED;
            timer         <= '0;
            sys.active    <= 1'b0;
            sys.pending   <= 1'b0;
            sys.alarm     <= 1'b0;
            sys.siren     <= 1'b0;
            sys.alarm_mem <= 1'b0;
        end else if (disarm_hit) begin
            state         <= DISARMED;
            timer         <= '0;
            sys.active    <= 1'b0;
            sys.pending   <= 1'b0;
            sys.alarm     <= 1'b0;
            sys.siren     <= 1'b0;
            sys.alarm_mem <= 1'b0;
        end else begin
            case (state)
                DISARMED: begin
                    if (arm_hit) begin
                        state       <= EXIT;
                        timer       <= EXIT_LOAD;
                        sys.active  <= 1'b1;
                        sys.pending <= 1'b1;
                    end
                end
                EXIT: begin
                    if (timer == '0) begin
                        state       <= ARMED;
                        sys.pending <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ARMED: begin
                    if (intrude) begin
                        state         <= ALARM;
                        timer         <= SIREN_LOAD;
                        sys.alarm     <= 1'b1;
                        sys.siren     <= 1'b1;
                        sys.alarm_mem <= 1'b1;
                    end else if (door) begin
                        state       <= ENTRY;
                        timer       <= ENTRY_LOAD;
                        sys.pending <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (intrude || timer == '0) begin
                        state         <= ALARM;
                        timer         <= SIREN_LOAD;
                        sys.pending   <= 1'b0;
                        sys.alarm     <= 1'b1;
                        sys.siren     <= 1'b1;
                        sys.alarm_mem <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ALARM: begin
                    // Siren times out but the alarm itself holds until disarm.
                    if (sys.siren) begin
                        if (timer == '0) begin
                            sys.siren <= 1'b0;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                default: begin
                    state         <= DISARMED;
                    timer         <= '0;
                    sys.active    <= 1'b0;
                    sys.pending   <= 1'b0;
                    sys.alarm     <= 1'b0;
                    sys.siren     <= 1'b0;
                    sys.alarm_mem <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: directed scenarios plus random traffic,
// checked every cycle against a countdown-based behavioural model.
module tb_alarm_sequencer;
    import alarm_pkg::*;

    localparam int EXIT_N  = 4;
    localparam int ENTRY_N = 3;
    localparam int SIREN_N = 5;
    localparam int FAILS_N = 3;
    localparam int LOCK_N  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alarm_sequencer_if sys();

    alarm_sequencer #(
        .ARM_CODE       (5'd31),
        .DISARM_CODE    (5'd4),
        .EXIT_CYCLES    (EXIT_N),
        .ENTRY_CYCLES   (ENTRY_N),
        .SIREN_CYCLES   (SIREN_N),
        .MAX_FAILS      (FAILS_N),
        .LOCKOUT_CYCLES (LOCK_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sys   (sys)
    );

    always #5 clk = ~clk;

    // Expected {active, pending, alarm, siren, alarm_mem, locked} per clock edge.
    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: remaining-cycle counts rather than an explicit state.
    bit armed, in_alarm, mem;
    int exit_left, entry_left, siren_left, fails, lock_left;

    function automatic logic [5:0] model_out();
        return {armed, (exit_left > 0) || (entry_left > 0), in_alarm,
                siren_left > 0, mem, lock_left > 0};
    endfunction

    task automatic model_reset();
        armed = 0; in_alarm = 0; mem = 0;
        exit_left = 0; entry_left = 0; siren_left = 0; fails = 0; lock_left = 0;
    endtask

    task automatic raise_alarm();
        entry_left = 0;
        in_alarm   = 1;
        mem        = 1;
        siren_left = SIREN_N;
    endtask

    task automatic model_step(input bit m1, input bit m2, input bit rd,
                              input bit cv, input logic [4:0] c);
        bit is_locked, acc, arm, dis, wr, intr;
        is_locked = lock_left > 0;
        acc  = cv && !is_locked;
        arm  = acc && (c == 5'd31);
        dis  = acc && (c == 5'd4);
        wr   = acc && !arm && !dis;
        intr = m1 || m2;

        if (is_locked) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (arm || dis) begin
            fails = 0;
        end else if (wr) begin
            fails++;
            if (fails >= FAILS_N) begin
                fails     = FAILS_N;
                lock_left = LOCK_N;
            end
        end

        if (dis) begin
            armed = 0; exit_left = 0; entry_left = 0;
            in_alarm = 0; siren_left = 0; mem = 0;
        end else if (!armed) begin
            if (arm) begin
                armed     = 1;
                exit_left = EXIT_N;
            end
        end else if (exit_left > 0) begin
            exit_left--;
        end else if (in_alarm) begin
            if (siren_left > 0) siren_left--;
        end else if (entry_left > 0) begin
            if (intr || entry_left == 1) raise_alarm();
            else entry_left--;
        end else if (intr) begin
            raise_alarm();
        end else if (rd) begin
            entry_left = ENTRY_N;
        end
    endtask

    task automatic drive(input bit m1, input bit m2, input bit rd,
                         input bit cv, input logic [4:0] c);
        @(negedge clk);
        rst_n          = 1'b1;
        sys.motion1    = m1;
        sys.motion2    = m2;
        sys.reed       = rd;
        sys.code_valid = cv;
        sys.code       = c;
        model_step(m1, m2, rd, cv, c);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 5'd0);
    endtask

    task automatic key(input logic [4:0] c);
        drive(0, 0, 0, 1, c);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n          = 1'b0;
            sys.motion1    = 1'b0;
            sys.motion2    = 1'b0;
            sys.reed       = 1'b0;
            sys.code_valid = 1'b0;
            sys.code       = 5'd0;
            model_reset();
            exp_q.push_back(model_out());
        end
    endtask

    logic [5:0] mon_exp;
    logic [5:0] mon_act;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {sys.active, sys.pending, sys.alarm, sys.siren,
                       sys.alarm_mem, sys.locked};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t act/pend/alm/sir/mem/lck actual=%b required=%b",
                         $time, mon_act, mon_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, k;
        bit m1, m2, rd, cv;
        logic [4:0] c;

        sys.motion1 = 1'b0; sys.motion2 = 1'b0; sys.reed = 1'b0;
        sys.code_valid = 1'b0; sys.code = 5'd0;
        model_reset();

        do_reset(2);

        // Arm, let exit delay run out.
        key(5'd31);
        idle(6);

        // Door opens, entry delay expires, siren runs then stops; disarm clears all.
        drive(0, 0, 1, 0, 5'd0);
        idle(ENTRY_N + SIREN_N + 3);
        key(5'd4);
        idle(2);

        // Disarm during entry delay.
        key(5'd31);
        idle(EXIT_N + 1);
        drive(0, 0, 1, 0, 5'd0);
        idle(1);
        key(5'd4);
        idle(3);

        // Disarm and intrusion in the same cycle: disarm wins.
        key(5'd31);
        idle(EXIT_N + 1);
        drive(0, 0, 1, 0, 5'd0);
        drive(1, 0, 0, 1, 5'd4);
        idle(2);

        // Motion during exit is ignored; still present once armed -> alarm.
        drive(1, 0, 0, 1, 5'd31);
        for (int i = 0; i < EXIT_N + 3; i++) drive(1, 0, 0, 0, 5'd0);
        key(5'd4);
        idle(2);

        // Three wrong codes -> lockout; disarm ignored while locked.
        key(5'd7);
        key(5'd9);
        key(5'd12);
        key(5'd4);
        key(5'd31);
        idle(LOCK_N);
        key(5'd4);
        key(5'd5);
        key(5'd31);
        idle(2);
        key(5'd4);

        // Reset while siren sounds, then re-arm.
        key(5'd31);
        idle(EXIT_N + 1);
        drive(0, 1, 0, 0, 5'd0);
        idle(2);
        do_reset(1);
        key(5'd31);
        idle(EXIT_N + 2);
        key(5'd4);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset(1);
            end else begin
                m1 = ($urandom_range(0, 39) == 0);
                m2 = ($urandom_range(0, 39) == 0);
                rd = ($urandom_range(0, 24) == 0);
                cv = ($urandom_range(0, 5) == 0);
                k  = $urandom_range(0, 3);
                if (k == 0)      c = 5'd31;
                else if (k == 1) c = 5'd4;
                else             c = 5'($urandom_range(0, 31));
                drive(m1, m2, rd, cv, c);
            end
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expectations actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
